// File: rtl/mem_store_packer_if.sv
// Control-side and data-memory-side signals of the store packer, bundled for port connection.
// The mem_be lane enables exist only when MEM_STORE_PACKER_BYTE_ENABLE_EN is defined.
interface mem_store_packer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;
`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
    logic [3:0]            mem_be;

    modport master (output start, op, addr, wdata, mem_rdata, mem_ready,
                    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata, mem_be);
    modport slave  (input  start, op, addr, wdata, mem_rdata, mem_ready,
                    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata, mem_be);
`else
    modport master (output start, op, addr, wdata, mem_rdata, mem_ready,
                    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata);
    modport slave  (input  start, op, addr, wdata, mem_rdata, mem_ready,
                    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata);
`endif
endinterface

// File: rtl/mem_store_packer.sv
// Narrows a register value to word/halfword/byte and stores it into word-wide memory,
// using read-modify-write by default or lane enables when MEM_STORE_PACKER_BYTE_ENABLE_EN is defined.
module mem_store_packer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int RMW_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    mem_store_packer_if.slave bus
);
    localparam int         CNT_W = $clog2(RMW_TIMEOUT + 1);
    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, FIN} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      timeoutCnt_q;
    logic                  armed_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic                  memRd_q;
    logic                  memWr_q;
    logic [31:0]           memWdata_q;
    logic                  badReq_d;
    logic                  timeoutHit_d;

    assign badReq_d = (bus.op == 2'b11) ||
                      ((bus.op == OP_SW) && (bus.addr[1:0] != 2'b00)) ||
                      ((bus.op == OP_SH) && bus.addr[0]);
    assign timeoutHit_d = (timeoutCnt_q == CNT_W'(RMW_TIMEOUT - 1));

`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
    logic [3:0]  memBe_q;
    logic [31:0] replData_d;
    logic [3:0]  laneBe_d;

    always_comb begin
        replData_d = {2{bus.wdata[15:0]}};
        laneBe_d   = bus.addr[1] ? 4'b1100 : 4'b0011;
        if (bus.op == OP_SB) begin
            replData_d = {4{bus.wdata[7:0]}};
            laneBe_d   = 4'b0001 << bus.addr[1:0];
        end
    end

    assign bus.mem_be = memBe_q;
`else
    logic [1:0]  opKind_q;
    logic [1:0]  laneSel_q;
    logic [15:0] storeData_q;
    logic [31:0] mergedWord_d;

    // memWdata_q holds the captured read word while in MERGE; overlay the new lanes on it.
    always_comb begin
        mergedWord_d = memWdata_q;
        if (opKind_q == OP_SB) begin
            case (laneSel_q)
                2'd0:    mergedWord_d[7:0]   = storeData_q[7:0];
                2'd1:    mergedWord_d[15:8]  = storeData_q[7:0];
                2'd2:    mergedWord_d[23:16] = storeData_q[7:0];
                default: mergedWord_d[31:24] = storeData_q[7:0];
            endcase
        end else if (laneSel_q[1]) begin
            mergedWord_d[31:16] = storeData_q;
        end else begin
            mergedWord_d[15:0] = storeData_q;
        end
    end
`endif

    // armed_q blocks a start that coincides with the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            memAddr_q    <= '0;
            memRd_q      <= 1'b0;
            memWr_q      <= 1'b0;
            memWdata_q   <= '0;
`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
            memBe_q      <= 4'b0000;
`else
            opKind_q     <= 2'b00;
            laneSel_q    <= 2'b00;
            storeData_q  <= '0;
`endif
        end else begin
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && armed_q) begin
                        busy_q       <= 1'b1;
                        memAddr_q    <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                        timeoutCnt_q <= '0;
`ifndef MEM_STORE_PACKER_BYTE_ENABLE_EN
                        opKind_q     <= bus.op;
                        laneSel_q    <= bus.addr[1:0];
                        storeData_q  <= bus.wdata[15:0];
`endif
                        if (badReq_d) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (bus.op == OP_SW) begin
                            state_q    <= WRITE;
                            memWr_q    <= 1'b1;
                            memWdata_q <= bus.wdata;
`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
                            memBe_q    <= 4'b1111;
`endif
                        end else begin
`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
                            state_q    <= WRITE;
                            memWr_q    <= 1'b1;
                            memWdata_q <= replData_d;
                            memBe_q    <= laneBe_d;
`else
                            state_q    <= READ;
                            memRd_q    <= 1'b1;
`endif
                        end
                    end
                end
`ifndef MEM_STORE_PACKER_BYTE_ENABLE_EN
                READ: begin
                    if (bus.mem_ready) begin
                        state_q    <= MERGE;
                        memRd_q    <= 1'b0;
                        memWdata_q <= bus.mem_rdata;
                    end else if (timeoutHit_d) begin
                        state_q <= FIN;
                        memRd_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 1'b1;
                    end
                end
                MERGE: begin
                    state_q      <= WRITE;
                    memWr_q      <= 1'b1;
                    memWdata_q   <= mergedWord_d;
                    timeoutCnt_q <= '0;
                end
`endif
                WRITE: begin
                    if (bus.mem_ready || timeoutHit_d) begin
                        state_q <= FIN;
                        memWr_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= !bus.mem_ready;
`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
                        memBe_q <= 4'b0000;
`endif
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_rd    = memRd_q;
    assign bus.mem_wr    = memWr_q;
    assign bus.mem_wdata = memWdata_q;
endmodule

// File: tb/tb_mem_store_packer.sv
// Directed self-checking bench for mem_store_packer: word/half/byte stores, alignment errors,
// memory timeout and asynchronous reset during a write.
module tb_mem_store_packer;
    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   rdCycles;
    int   wrCycles;
    int   wrCount;
    int   bothHigh;
    logic [31:0] lastWrAddr;
    logic [31:0] lastWrData;
    logic [31:0] lastRdAddr;
    logic [3:0]  lastWrBe;

    mem_store_packer_if #(.ADDR_WIDTH(32)) bus ();

    mem_store_packer #(.ADDR_WIDTH(32), .RMW_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: counts strobe cycles and records completed transfers.
    always @(posedge clk) begin
        if (bus.mem_rd) rdCycles <= rdCycles + 1;
        if (bus.mem_wr) wrCycles <= wrCycles + 1;
        if (bus.mem_rd && bus.mem_wr) bothHigh <= bothHigh + 1;
        if (bus.mem_rd && bus.mem_ready) lastRdAddr <= bus.mem_addr;
        if (bus.mem_wr && bus.mem_ready) begin
            wrCount    <= wrCount + 1;
            lastWrAddr <= bus.mem_addr;
            lastWrData <= bus.mem_wdata;
`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
            lastWrBe   <= bus.mem_be;
`else
            lastWrBe   <= 4'b0000;
`endif
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] addrIn, input logic [31:0] dataIn);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = opIn;
        bus.addr  = addrIn;
        bus.wdata = dataIn;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Cycle 1 is the cycle start is presented; returns 0 if done never arrives.
    task automatic waitDone(output int cyc, output logic errOut);
        cyc = 2;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = 0;
        errOut = bus.err;
    endtask

    int   doneCyc;
    logic errSeen;
    int   rd0;
    int   wr0;
    int   cnt0;
    logic [1:0]  badOp   [3];
    logic [31:0] badAddr [3];

    initial begin
        checks = 0; fails = 0;
        rdCycles = 0; wrCycles = 0; wrCount = 0; bothHigh = 0;
        lastWrAddr = '0; lastWrData = '0; lastRdAddr = '0; lastWrBe = '0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
        checkOutput("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);

        $display("[TB] start coincident with reset release");
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1; bus.op = 2'b00; bus.addr = 32'h40; bus.wdata = 32'h0BADF00D;
        cnt0 = wrCount;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ignored_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ignored_no_write", 32'(wrCount - cnt0), 32'd0);

        $display("[TB] SW aligned");
        rd0 = rdCycles; cnt0 = wrCount;
        applyStimulus(2'b00, 32'h10, 32'hDEADBEEF);
        checkOutput("sw_busy", {31'd0, bus.busy}, 32'd1);
        waitDone(doneCyc, errSeen);
        checkOutput("sw_done_cycle", 32'(doneCyc), 32'd3);
        checkOutput("sw_err", {31'd0, errSeen}, 32'd0);
        checkOutput("sw_write_count", 32'(wrCount - cnt0), 32'd1);
        checkOutput("sw_write_addr", lastWrAddr, 32'h10);
        checkOutput("sw_write_data", lastWrData, 32'hDEADBEEF);
        checkOutput("sw_no_read", 32'(rdCycles - rd0), 32'd0);
        @(negedge clk);
        checkOutput("sw_done_pulse", {31'd0, bus.done}, 32'd0);
        checkOutput("sw_busy_drop", {31'd0, bus.busy}, 32'd0);

`ifdef MEM_STORE_PACKER_BYTE_ENABLE_EN
        $display("[TB] SB with lane enables");
        applyStimulus(2'b10, 32'h03, 32'h0000005A);
        waitDone(doneCyc, errSeen);
        checkOutput("be_done_cycle", 32'(doneCyc), 32'd3);
        checkOutput("be_err", {31'd0, errSeen}, 32'd0);
        checkOutput("be_lanes", {28'd0, lastWrBe}, 32'h8);
        checkOutput("be_data", lastWrData, 32'h5A5A5A5A);
        checkOutput("be_idle", {28'd0, bus.mem_be}, 32'h0);
`else
        $display("[TB] SB read-modify-write");
        bus.mem_rdata = 32'h11223344;
        applyStimulus(2'b10, 32'h22, 32'h000000AB);
        waitDone(doneCyc, errSeen);
        checkOutput("sb_done_cycle", 32'(doneCyc), 32'd5);
        checkOutput("sb_err", {31'd0, errSeen}, 32'd0);
        checkOutput("sb_read_addr", lastRdAddr, 32'h20);
        checkOutput("sb_write_addr", lastWrAddr, 32'h20);
        checkOutput("sb_write_data", lastWrData, 32'h11AB3344);

        $display("[TB] SH read-modify-write");
        applyStimulus(2'b01, 32'h26, 32'h0000CAFE);
        waitDone(doneCyc, errSeen);
        checkOutput("sh_done_cycle", 32'(doneCyc), 32'd5);
        checkOutput("sh_write_addr", lastWrAddr, 32'h24);
        checkOutput("sh_write_data", lastWrData, 32'hCAFE3344);
`endif

        $display("[TB] rejected requests");
        badOp[0] = 2'b01; badAddr[0] = 32'h31;
        badOp[1] = 2'b00; badAddr[1] = 32'h32;
        badOp[2] = 2'b11; badAddr[2] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            rd0 = rdCycles; wr0 = wrCycles;
            applyStimulus(badOp[i], badAddr[i], 32'h12345678);
            waitDone(doneCyc, errSeen);
            checkOutput($sformatf("bad%0d_done_cycle", i), 32'(doneCyc), 32'd2);
            checkOutput($sformatf("bad%0d_err", i), {31'd0, errSeen}, 32'd1);
            checkOutput($sformatf("bad%0d_no_strobe", i), 32'(rdCycles - rd0 + wrCycles - wr0), 32'd0);
        end

`ifndef MEM_STORE_PACKER_BYTE_ENABLE_EN
        $display("[TB] SB read timeout");
        bus.mem_ready = 1'b0;
        rd0 = rdCycles; wr0 = wrCycles;
        applyStimulus(2'b10, 32'h22, 32'h000000AB);
        waitDone(doneCyc, errSeen);
        checkOutput("to_done_cycle", 32'(doneCyc), 32'd17);
        checkOutput("to_err", {31'd0, errSeen}, 32'd1);
        checkOutput("to_read_cycles", 32'(rdCycles - rd0), 32'd15);
        checkOutput("to_no_write", 32'(wrCycles - wr0), 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
`endif

        $display("[TB] reset during write");
        bus.mem_ready = 1'b0;
        applyStimulus(2'b00, 32'h50, 32'hA5A5A5A5);
        checkOutput("rw_write_active", {31'd0, bus.mem_wr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rw_async_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        checkOutput("rw_async_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        applyStimulus(2'b00, 32'h54, 32'h12345678);
        waitDone(doneCyc, errSeen);
        checkOutput("rw_sw_done_cycle", 32'(doneCyc), 32'd3);
        checkOutput("rw_sw_err", {31'd0, errSeen}, 32'd0);
        checkOutput("rw_sw_addr", lastWrAddr, 32'h54);
        checkOutput("rw_sw_data", lastWrData, 32'h12345678);

        checkOutput("rd_wr_exclusive", 32'(bothHigh), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
